// File: rtl/serial_paralelo_rx_l1.sv
// Serial-to-parallel receive stage: comma-based byte alignment, lock qualification,
// and payload extraction (IDLE/COMMA fill dropped) for one serial lane.
module serial_paralelo_rx_l1 #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          stb_q, stb_d;
  logic          active_q, active_d;

  logic [7:0] nb;
  logic       boundary;

  assign nb       = {sr_q[6:0], serial_in};
  assign boundary = (bit_cnt_q == 3'd7);
  assign sr_d     = nb;

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      stb_q       <= stb_d;
      active_q    <= active_d;
    end
  end

  // Next state: HUNT slides bit by bit; SYNC/LOCKED only look at byte boundaries.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      HUNT: begin
        bit_cnt_d = '0;
        if (nb == COMMA) begin
          comma_cnt_d = CW'(1);
          state_d     = (LOCK_COUNT == 1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (boundary) begin
          if (nb == COMMA) begin
            comma_cnt_d = comma_cnt_q + CW'(1);
            if (comma_cnt_q == CW'(LOCK_COUNT - 1)) state_d = LOCKED;
          end else begin
            comma_cnt_d = '0;
            state_d     = HUNT;
          end
        end
      end
      LOCKED: ;
      default: begin
        state_d     = HUNT;
        bit_cnt_d   = '0;
        comma_cnt_d = '0;
      end
    endcase
  end

  // Outputs: the lock-completing comma is never forwarded since LOCKED is not yet current.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    stb_d    = 1'b0;
    active_d = active_q;
    if (state_q != LOCKED && state_d == LOCKED) active_d = 1'b1;
    if (state_q == LOCKED && boundary) begin
      if (nb == COMMA || nb == IDLE) begin
        valid_d = 1'b0;
      end else begin
        data_d  = nb;
        valid_d = 1'b1;
        stb_d   = 1'b1;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule
